async_transmitter_fifo: RTL

Buffered RS-232 transmitter and the TX counterpart of the serial receive path. Accepts bytes through a valid/ready handshake into an internal FIFO. Serializes them onto `TxD` as 8-N-1 or 8-N-2 frames, LSB first, at a fixed baud rate derived from the system clock. Sits between on-chip command/response logic and the board UART pin, so host-bound bursts do not stall the producer.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/tx_byte_fifo.sv | 49 ++++
 rtl/async_transmitter_fifo.sv | 132 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding, frame width and a ceil-log2 helper.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } txState_t;

  // Ceiling log2; log2(1) = 0.
  function automatic int unsigned log2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tx_byte_fifo.sv
// Synchronous byte FIFO with extra-MSB pointers; first-word fall-through read data.
module tx_byte_fifo
  import uart_pkg::*;
#(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = UART_DATA_BITS,
  localparam int unsigned AW   = log2(Depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             rd,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [Width-1:0] mem [Depth];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic             rdEn;
  logic             wrEn;

  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign count = wrPtr - rdPtr;
  assign dout  = mem[rdPtr[AW-1:0]];

  // A write into a full FIFO still lands when the same edge frees a slot.
  assign rdEn = rd && !empty;
  assign wrEn = wr && (!full || rdEn);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + (AW+1)'(1);
      if (rdEn) rdPtr <= rdPtr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrPtr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/async_transmitter_fifo.sv
// Buffered 8-N-1/8-N-2 UART transmitter: byte FIFO in front of a bit-timed serializer.
module async_transmitter_fifo
  import uart_pkg::*;
#(
  parameter int unsigned ClkFrequency = 100000000,
  parameter int unsigned Baud         = 38400,
  parameter int unsigned StopBits     = 2,
  parameter int unsigned FifoDepth    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      TxD_start,
  input  logic [7:0]                TxD_data,
  output logic                      TxD_ready,
  output logic                      TxD_drop,
  output logic [log2(FifoDepth):0]  TxD_count,
  output logic                      TxD_busy,
  output logic                      TxD
);

  localparam int unsigned DIV = (ClkFrequency + Baud / 2) / Baud;
  localparam int unsigned TW  = (log2(DIV) > 0) ? log2(DIV) : 1;
  localparam int unsigned IW  = log2(UART_DATA_BITS);

  if (DIV < 2) begin : gBadDiv
    $fatal(1, "async_transmitter_fifo: clocks per bit must be at least 2");
  end
  if (StopBits != 1 && StopBits != 2) begin : gBadStop
    $fatal(1, "async_transmitter_fifo: StopBits must be 1 or 2");
  end
  if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : gBadDepth
    $fatal(1, "async_transmitter_fifo: FifoDepth must be a power of 2, at least 2");
  end

  txState_t                  state;
  logic [TW-1:0]             bitTimer;
  logic [IW-1:0]             bitIdx;
  logic [UART_DATA_BITS-1:0] shift;
  logic [UART_DATA_BITS-1:0] fifoDout;
  logic                      fifoFull;
  logic                      fifoEmpty;
  logic                      bitEnd;
  logic                      stopDone;
  logic                      pop;
  logic                      accept;

  tx_byte_fifo #(
    .Depth (FifoDepth),
    .Width (UART_DATA_BITS)
  ) uFifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (TxD_start),
    .rd    (pop),
    .din   (TxD_data),
    .dout  (fifoDout),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (TxD_count)
  );

  assign bitEnd    = (bitTimer == TW'(DIV - 1));
  assign stopDone  = (state == STOP) && bitEnd && (bitIdx == IW'(StopBits - 1));
  assign pop       = !fifoEmpty && ((state == IDLE) || stopDone);
  assign accept    = TxD_start && (!fifoFull || pop);
  assign TxD_ready = !fifoFull;

  // Serializer: back-to-back frames chain straight from the last stop bit into START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bitTimer <= '0;
      bitIdx   <= '0;
      shift    <= '0;
      TxD      <= 1'b1;
      TxD_busy <= 1'b0;
      TxD_drop <= 1'b0;
    end else begin
      TxD_drop <= TxD_start && !accept;
      TxD_busy <= accept || !(fifoEmpty && ((state == IDLE) || stopDone));
      bitTimer <= ((state == IDLE) || bitEnd) ? '0 : bitTimer + TW'(1);
      case (state)
        IDLE: begin
          if (pop) begin
            shift <= fifoDout;
            state <= START;
            TxD   <= 1'b0;
          end
        end
        START: begin
          if (bitEnd) begin
            state  <= DATA;
            bitIdx <= '0;
            TxD    <= shift[0];
          end
        end
        DATA: begin
          if (bitEnd) begin
            shift <= shift >> 1;
            if (bitIdx == IW'(UART_DATA_BITS - 1)) begin
              state  <= STOP;
              bitIdx <= '0;
              TxD    <= 1'b1;
            end else begin
              bitIdx <= bitIdx + IW'(1);
              TxD    <= shift[1];
            end
          end
        end
        STOP: begin
          if (stopDone) begin
            if (pop) begin
              shift <= fifoDout;
              state <= START;
              TxD   <= 1'b0;
            end else begin
              state <= IDLE;
              TxD   <= 1'b1;
            end
          end else if (bitEnd) begin
            bitIdx <= bitIdx + IW'(1);
          end
        end
        default: begin
          state <= IDLE;
          TxD   <= 1'b1;
        end
      endcase
    end
  end

endmodule
